// File: rtl/du_jump_ctrl.sv
// du_jump_ctrl: dispatch-unit jump handling for a MIPS-style front end.
// Takes the IFQ head into a one-entry registered dispatch slot. It resolves
// JAL (RAS push and redirect) and JR $31 (RAS pop and redirect) in the same
// cycle the head is accepted. After a redirect it spends one FLUSH cycle so
// that stale IFQ entries are not accepted.
// Optional build macro DU_RAS_OCC_GUARD_EN adds a RAS occupancy counter.
// With the counter, a JR $31 against an empty RAS is not predicted.
// The JAL target concatenation assumes ADDR_WIDTH >= 29.
module du_jump_ctrl #(
    parameter int RAS_DEPTH  = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ifq_valid,
    input  logic [0:31]           ifq_instr,
    input  logic [0:ADDR_WIDTH-1] ifq_pc,
    output logic                  du_rd_ifq,
    output logic                  du_jal_push,
    output logic [0:ADDR_WIDTH-1] du_jal_push_din,
    output logic                  du_jr31_pop,
    input  logic [0:ADDR_WIDTH-1] du_jr31_pop_dout,
    output logic                  du_redirect,
    output logic [0:ADDR_WIDTH-1] du_redirect_addr,
    output logic                  disp_valid,
    output logic [0:31]           disp_instr,
    output logic [0:ADDR_WIDTH-1] disp_pc,
    output logic                  disp_pred,
    input  logic                  disp_ready,
    input  logic                  cdb_flush
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic                  disp_valid_reg;
    logic [0:31]           disp_instr_reg;
    logic [0:ADDR_WIDTH-1] disp_pc_reg;
    logic                  disp_pred_reg;

    logic                  accept;
    logic                  do_push;
    logic                  do_pop;
    logic                  redirect;
    logic                  ras_ok;

    // Decode of the IFQ head (bit 0 is the MSB of the instruction word)
    logic                  is_jal;
    logic                  is_jr31;
    logic [0:ADDR_WIDTH-1] pc_plus4;
    logic [0:ADDR_WIDTH-1] jal_target;

    assign is_jal     = (ifq_instr[0:5] == 6'b000011);
    assign is_jr31    = (ifq_instr[0:5] == 6'b000000) &&
                        (ifq_instr[6:10] == 5'b11111) &&
                        (ifq_instr[26:31] == 6'b001000);
    assign pc_plus4   = ifq_pc + ADDR_WIDTH'(4);
    assign jal_target = {pc_plus4[0:ADDR_WIDTH-29], ifq_instr[6:31], 2'b00};

`ifdef DU_RAS_OCC_GUARD_EN
    localparam int OCC_W = $clog2(RAS_DEPTH) + 1;

    logic [0:OCC_W-1] occ_reg, occ_next;

    assign ras_ok = (occ_reg != '0);

    // Occupancy tracks pushes (saturating at RAS_DEPTH) and pops
    always_comb begin
        occ_next = occ_reg;
        if (do_push && (occ_reg != OCC_W'(RAS_DEPTH)))
            occ_next = occ_reg + OCC_W'(1);
        else if (do_pop)
            occ_next = occ_reg - OCC_W'(1);
    end

    // Occupancy counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            occ_reg <= '0;
        else
            occ_reg <= occ_next;
    end
`else
    // Without the counter, a RAS of any real depth is always trusted
    assign ras_ok = (RAS_DEPTH > 0);
`endif

    // Accept decision, jump strobes and RUN/FLUSH next-state logic
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        redirect   = 1'b0;

        accept   = ifq_valid & ~reset & (state_reg == ST_RUN) &
                   (~disp_valid_reg | disp_ready) & ~cdb_flush;
        do_push  = accept & is_jal;
        do_pop   = accept & is_jr31 & ras_ok;
        redirect = do_push | do_pop;

        case (state_reg)
            ST_RUN:   if (redirect) state_next = ST_FLUSH;
            ST_FLUSH: state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase

        // A back-end flush always returns the front end to RUN
        if (cdb_flush)
            state_next = ST_RUN;
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= ST_RUN;
        else
            state_reg <= state_next;
    end

    // Dispatch slot: load on accept, drain on disp_ready, drop on cdb_flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_valid_reg <= 1'b0;
            disp_instr_reg <= '0;
            disp_pc_reg    <= '0;
            disp_pred_reg  <= 1'b0;
        end else if (cdb_flush) begin
            disp_valid_reg <= 1'b0;
        end else if (accept) begin
            disp_valid_reg <= 1'b1;
            disp_instr_reg <= ifq_instr;
            disp_pc_reg    <= ifq_pc;
            disp_pred_reg  <= is_jr31 & ras_ok;
        end else if (disp_ready) begin
            disp_valid_reg <= 1'b0;
        end
    end

    assign du_rd_ifq        = accept;
    assign du_jal_push      = do_push;
    assign du_jal_push_din  = do_push ? pc_plus4 : '0;
    assign du_jr31_pop      = do_pop;
    assign du_redirect      = redirect;
    assign du_redirect_addr = do_pop  ? du_jr31_pop_dout :
                              do_push ? jal_target : '0;

    assign disp_valid = disp_valid_reg;
    assign disp_instr = disp_instr_reg;
    assign disp_pc    = disp_pc_reg;
    assign disp_pred  = disp_pred_reg;

endmodule

// File: tb/tb_du_jump_ctrl.sv
// tb_du_jump_ctrl: directed self-checking bench for du_jump_ctrl.
// Exercises JAL/JR31 handling, the FLUSH cycle, dispatch stalls, cdb_flush,
// address wrap and asynchronous reset. The RAS occupancy saturation sequence
// is included when DU_RAS_OCC_GUARD_EN is defined.
module tb_du_jump_ctrl;

    localparam int AW = 32;

    localparam logic [31:0] JAL_100  = 32'h0C00_0040; // target field 0x40 -> 0x100
    localparam logic [31:0] ADD_I    = 32'h0022_1820; // add $3,$1,$2
    localparam logic [31:0] JR31_I   = 32'h03E0_0008; // jr $31
    localparam logic [31:0] JR30_I   = 32'h03C0_0008; // jr $30 (not a return)

    logic          clk = 1'b0;
    logic          reset;
    logic          ifq_valid;
    logic [0:31]   ifq_instr;
    logic [0:AW-1] ifq_pc;
    logic          du_rd_ifq;
    logic          du_jal_push;
    logic [0:AW-1] du_jal_push_din;
    logic          du_jr31_pop;
    logic [0:AW-1] du_jr31_pop_dout;
    logic          du_redirect;
    logic [0:AW-1] du_redirect_addr;
    logic          disp_valid;
    logic [0:31]   disp_instr;
    logic [0:AW-1] disp_pc;
    logic          disp_pred;
    logic          disp_ready;
    logic          cdb_flush;

    int checks   = 0;
    int failures = 0;

    du_jump_ctrl #(.RAS_DEPTH(4), .ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .ifq_valid        (ifq_valid),
        .ifq_instr        (ifq_instr),
        .ifq_pc           (ifq_pc),
        .du_rd_ifq        (du_rd_ifq),
        .du_jal_push      (du_jal_push),
        .du_jal_push_din  (du_jal_push_din),
        .du_jr31_pop      (du_jr31_pop),
        .du_jr31_pop_dout (du_jr31_pop_dout),
        .du_redirect      (du_redirect),
        .du_redirect_addr (du_redirect_addr),
        .disp_valid       (disp_valid),
        .disp_instr       (disp_instr),
        .disp_pc          (disp_pc),
        .disp_pred        (disp_pred),
        .disp_ready       (disp_ready),
        .cdb_flush        (cdb_flush)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an IFQ head, let the combinational outputs settle, log the cycle
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        ifq_valid = v;
        ifq_instr = ins;
        ifq_pc    = pc;
        #1;
        $display("txn t=%0t valid=%0d pc=0x%08h instr=0x%08h rd=%0d push=%0d pop=%0d redir=%0d addr=0x%08h",
                 $time, v, pc, ins, du_rd_ifq, du_jal_push, du_jr31_pop, du_redirect, du_redirect_addr);
    endtask

    initial begin
        reset            = 1'b1;
        ifq_valid        = 1'b0;
        ifq_instr        = '0;
        ifq_pc           = '0;
        du_jr31_pop_dout = '0;
        disp_ready       = 1'b1;
        cdb_flush        = 1'b0;

        // Reset state, with a JAL already waiting at the head
        drive(1'b1, JAL_100, 32'h0000_0100);
        step();
        step();
        check_val("rst_rd",        du_rd_ifq,   0);
        check_val("rst_push",      du_jal_push, 0);
        check_val("rst_redir",     du_redirect, 0);
        check_val("rst_pop",       du_jr31_pop, 0);
        check_val("rst_dvalid",    disp_valid,  0);
        check_val("rst_dpc",       disp_pc,     0);
        check_val("rst_dinstr",    disp_instr,  0);
        check_val("rst_dpred",     disp_pred,   0);

        // JAL at 0x100: push 0x104, redirect to 0x100
        reset = 1'b0;
        drive(1'b1, JAL_100, 32'h0000_0100);
        check_val("jal_rd",        du_rd_ifq,        1);
        check_val("jal_push",      du_jal_push,      1);
        check_val("jal_din",       du_jal_push_din,  32'h0000_0104);
        check_val("jal_redir",     du_redirect,      1);
        check_val("jal_addr",      du_redirect_addr, 32'h0000_0100);
        check_val("jal_pop",       du_jr31_pop,      0);
        step();
        // FLUSH cycle: slot holds the JAL, nothing accepted
        drive(1'b1, JAL_100, 32'h0000_0100);
        check_val("jal_dvalid",    disp_valid,  1);
        check_val("jal_dpc",       disp_pc,     32'h0000_0100);
        check_val("jal_dinstr",    disp_instr,  JAL_100);
        check_val("jal_dpred",     disp_pred,   0);
        check_val("flush_rd",      du_rd_ifq,   0);
        check_val("flush_push",    du_jal_push, 0);
        check_val("flush_redir",   du_redirect, 0);
        step();

        // Back in RUN: plain instruction, no strobes
        drive(1'b1, ADD_I, 32'h0000_0104);
        check_val("add_dvalid0",   disp_valid,  0);
        check_val("add_rd",        du_rd_ifq,   1);
        check_val("add_push",      du_jal_push, 0);
        check_val("add_redir",     du_redirect, 0);
        step();
        check_val("add_dvalid",    disp_valid,  1);
        check_val("add_dinstr",    disp_instr,  ADD_I);
        check_val("add_dpc",       disp_pc,     32'h0000_0104);

        // JR31 with RAS top 0x204
        du_jr31_pop_dout = 32'h0000_0204;
        drive(1'b1, JR31_I, 32'h0000_0200);
        check_val("jr_rd",         du_rd_ifq,        1);
        check_val("jr_pop",        du_jr31_pop,      1);
        check_val("jr_redir",      du_redirect,      1);
        check_val("jr_addr",       du_redirect_addr, 32'h0000_0204);
        check_val("jr_push",       du_jal_push,      0);
        step();
        check_val("jr_dpred",      disp_pred,   1);
        check_val("jr_dpc",        disp_pc,     32'h0000_0200);
        check_val("jr_flush_rd",   du_rd_ifq,   0);
        check_val("jr_flush_pop",  du_jr31_pop, 0);
        step();

        // jr $30 is not a return: no pop, no prediction
        drive(1'b1, JR30_I, 32'h0000_0208);
        check_val("jr30_rd",       du_rd_ifq,   1);
        check_val("jr30_pop",      du_jr31_pop, 0);
        check_val("jr30_redir",    du_redirect, 0);
        step();
        check_val("jr30_dvalid",   disp_valid,  1);
        check_val("jr30_dpred",    disp_pred,   0);

        // Dispatch stall for three cycles with a JAL waiting
        disp_ready = 1'b0;
        drive(1'b1, JAL_100, 32'h0000_0300);
        for (int i = 0; i < 3; i++) begin
            check_val("stall_rd",     du_rd_ifq,   0);
            check_val("stall_push",   du_jal_push, 0);
            check_val("stall_redir",  du_redirect, 0);
            check_val("stall_dvalid", disp_valid,  1);
            check_val("stall_dinstr", disp_instr,  JR30_I);
            check_val("stall_dpc",    disp_pc,     32'h0000_0208);
            step();
        end
        disp_ready = 1'b1;
        #1;
        check_val("unstall_rd",    du_rd_ifq,        1);
        check_val("unstall_push",  du_jal_push,      1);
        check_val("unstall_din",   du_jal_push_din,  32'h0000_0304);
        check_val("unstall_addr",  du_redirect_addr, 32'h0000_0100);
        step();
        check_val("unstall_dpc",   disp_pc,     32'h0000_0300);
        step();

        // cdb_flush with a valid slot and a JAL at the head
        drive(1'b1, ADD_I, 32'h0000_0400);
        step();
        check_val("pre_cdb_dvalid", disp_valid, 1);
        disp_ready = 1'b0;
        cdb_flush  = 1'b1;
        drive(1'b1, JAL_100, 32'h0000_0404);
        check_val("cdb_rd",        du_rd_ifq,   0);
        check_val("cdb_push",      du_jal_push, 0);
        check_val("cdb_redir",     du_redirect, 0);
        step();
        cdb_flush = 1'b0;
        #1;
        check_val("cdb_dvalid",    disp_valid,  0);
        check_val("cdb_rd_after",  du_rd_ifq,   1);
        disp_ready = 1'b1;
        step();
        step();

        // JAL return address wraps; region bits come from pc+4
        drive(1'b1, 32'h0C00_0001, 32'hFFFF_FFFC);
        check_val("wrap_din",      du_jal_push_din,  32'h0000_0000);
        check_val("wrap_addr",     du_redirect_addr, 32'h0000_0004);
        step();
        step();
        drive(1'b1, 32'h0C00_0010, 32'h1FFF_FFF0);
        check_val("region_din",    du_jal_push_din,  32'h1FFF_FFF4);
        check_val("region_addr",   du_redirect_addr, 32'h1000_0040);
        step();

        // Asynchronous reset in the middle of FLUSH
        check_val("pre_rst_dvalid", disp_valid, 1);
        reset = 1'b1;
        #1;
        check_val("arst_dvalid",   disp_valid,       0);
        check_val("arst_dpc",      disp_pc,          0);
        check_val("arst_dinstr",   disp_instr,       0);
        check_val("arst_rd",       du_rd_ifq,        0);
        check_val("arst_push",     du_jal_push,      0);
        check_val("arst_redir",    du_redirect,      0);
        check_val("arst_din",      du_jal_push_din,  0);
        check_val("arst_addr",     du_redirect_addr, 0);
        step();
        reset = 1'b0;
        drive(1'b1, ADD_I, 32'h0000_0500);
        check_val("post_rst_rd",   du_rd_ifq,   1);
        step();
        check_val("post_rst_dvalid", disp_valid, 1);

`ifdef DU_RAS_OCC_GUARD_EN
        // Five JALs saturate the occupancy at 4; the fifth JR31 is unpredicted
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, JAL_100, 32'h0000_0600 + 32'(i * 4));
            check_val("g_jal_push", du_jal_push, 1);
            step();
            step();
        end
        du_jr31_pop_dout = 32'h0000_0700;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, JR31_I, 32'h0000_0800 + 32'(i * 4));
            check_val("g_jr_rd",    du_rd_ifq,   1);
            check_val("g_jr_pop",   du_jr31_pop, (i < 4) ? 1 : 0);
            check_val("g_jr_redir", du_redirect, (i < 4) ? 1 : 0);
            step();
            check_val("g_jr_dpred", disp_pred,   (i < 4) ? 1 : 0);
            step();
        end
`endif

        ifq_valid = 1'b0;
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
